// File: rtl/aes_pkg.sv
// Shared AES package: block/byte types, block size, writer FSM states and
// the byte-select helper used by the block writer (and reusable by the core).
//   aes_block_t    : 128-bit AES block, byte 0 in bits [127:120]
//   aes_byte_t     : one byte
//   AES_NBYTES     : bytes per AES block
//   writer_state_t : IDLE / WRITE / DONE states of aes_block_writer
//   get_byte()     : returns byte idx of a block (byte 0 is the MSB byte)
package aes_pkg;

  localparam int unsigned AES_NBYTES = 16;

  typedef logic [127:0] aes_block_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } writer_state_t;

  function automatic aes_byte_t get_byte(input aes_block_t block, input logic [3:0] idx);
    logic [6:0] lsb;
    lsb = {4'd15 - idx, 3'b000};
    return block[lsb +: 8];
  endfunction

endpackage

// File: rtl/aes_block_writer.sv
// AES block writer: accepts one finished block on a valid/ready handshake
// and writes it byte-by-byte through an 8-bit Avalon-MM write master,
// starting at a base address captured on accept. Pulses done for one cycle
// after the last byte is accepted by the slave.
//
// Parameters:
//   NBYTES : bytes per block (power of two, 1..16)
//   ADDR_W : master address width
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : block handshake from the AES core
//   in_block            : block, byte i = in_block[8*NBYTES-1-8*i -: 8]
//   base_addr           : destination of byte 0, sampled on accept
//   busy                : block being written
//   done                : one-cycle pulse after the last byte is accepted
//   master_address      : byte address (base + idx, wraps mod 2^ADDR_W)
//   master_write        : write request
//   master_writedata    : byte being written
//   master_waitrequest  : slave stall
// Optional feature (macro AES_WRITER_AUTOINC_EN):
//   base_addr is only used on the first accept after reset; later blocks go
//   to an internal next_addr that advances by NBYTES at each done pulse.
module aes_block_writer
  import aes_pkg::*;
#(
  parameter int unsigned NBYTES = AES_NBYTES,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_block,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     master_address,
  output logic                  master_write,
  output logic [7:0]            master_writedata,
  input  logic                  master_waitrequest
);

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  writer_state_t     state_q, state_d;
  aes_block_t        blk_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        idx_q;
  logic              accept;
  logic              byte_ok;
  aes_block_t        blk_aligned;

  // Left-align the incoming block so byte 0 always sits in bits [127:120]
  // regardless of NBYTES, letting the shared get_byte() helper be used as-is.
  assign blk_aligned = aes_block_t'(in_block) << (128 - 8 * NBYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    in_ready         = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    accept           = 1'b0;
    byte_ok          = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy             = 1'b1;
        master_write     = 1'b1;
        master_address   = base_q + ADDR_W'(idx_q);
        master_writedata = get_byte(blk_q, idx_q);
        if (!master_waitrequest) begin
          byte_ok = 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_WRITER_AUTOINC_EN
  logic [ADDR_W-1:0] next_addr;
  logic              loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= '0;
      loaded    <= 1'b0;
      base_q    <= '0;
    end else begin
      if (accept) begin
        if (!loaded) begin
          base_q    <= base_addr;
          next_addr <= base_addr;
          loaded    <= 1'b1;
        end else begin
          base_q <= next_addr;
        end
      end
      if (state_q == DONE) next_addr <= next_addr + ADDR_W'(NBYTES);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      base_q <= '0;
    else if (accept) base_q <= base_addr;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      blk_q <= blk_aligned;
      idx_q <= '0;
    end else if (byte_ok && (idx_q != LAST_IDX)) begin
      idx_q <= idx_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_block_writer.sv
// Self-checking bench for aes_block_writer. A queue-based reference model
// turns each accepted block into its expected (address, byte) sequence and
// tracks handshake/busy/done expectations cycle by cycle.
module tb_aes_block_writer;

  localparam int unsigned NB = 16;
  localparam int unsigned AW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*NB-1:0] in_block = '0;
  logic [AW-1:0]   base_addr = '0;
  logic            busy;
  logic            done;
  logic [AW-1:0]   master_address;
  logic            master_write;
  logic [7:0]      master_writedata;
  logic            master_waitrequest = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  aes_block_writer #(.NBYTES(NB), .ADDR_W(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_block           (in_block),
    .base_addr          (base_addr),
    .busy               (busy),
    .done               (done),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [7:0]    exp_data_q[$];
  logic [AW-1:0] first_addr_log[$];
  int unsigned   acc_log[$];
  bit            active, exp_done, hold_pend, loaded;
  logic [AW-1:0] hold_addr, nxt;
  logic [7:0]    hold_data;
  int unsigned   cyc, acc_cyc, stalls, wr_in_blk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      active    = 0;
      exp_done  = 0;
      hold_pend = 0;
      loaded    = 0;
      wr_in_blk = 0;
    end else begin
      check("in_ready", in_ready, !active);
      check("busy", busy, active && !exp_done);
      check("done", done, exp_done);
      if (hold_pend) begin
        check("hold_write", master_write, 1);
        check("hold_addr", master_address, hold_addr);
        check("hold_data", master_writedata, hold_data);
      end
      hold_pend = 0;
      if (exp_done) begin
        check("done_latency", cyc - acc_cyc, NB + 1 + stalls);
        if (loaded) nxt = nxt + AW'(NB);
        active   = 0;
        exp_done = 0;
      end
      if (in_valid && in_ready) begin
        logic [AW-1:0] b;
`ifdef AES_WRITER_AUTOINC_EN
        if (!loaded) begin
          nxt    = base_addr;
          loaded = 1;
        end
        b = nxt;
`else
        b = base_addr;
`endif
        for (int i = 0; i < NB; i++) begin
          exp_addr_q.push_back(b + AW'(i));
          exp_data_q.push_back(8'(in_block >> (8 * (NB - 1 - i))));
        end
        active    = 1;
        acc_cyc   = cyc;
        stalls    = 0;
        wr_in_blk = 0;
        acc_log.push_back(cyc);
      end
      if (master_write && !master_waitrequest) begin
        if (exp_addr_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          if (wr_in_blk == 0) first_addr_log.push_back(master_address);
          check("wr_addr", master_address, exp_addr_q.pop_front());
          check("wr_data", master_writedata, exp_data_q.pop_front());
          wr_in_blk++;
          if (exp_addr_q.size() == 0) exp_done = 1;
        end
      end
      if (master_write && master_waitrequest) begin
        stalls++;
        hold_pend = 1;
        hold_addr = master_address;
        hold_data = master_writedata;
      end
    end
  end

  // ---------------- slave stall driver ----------------
  logic [AW-1:0] stall_addr = '0;
  int unsigned   stall_left = 0;
  bit            rand_wait = 0;

  always @(posedge clk) begin
    #1;
    if (master_write && stall_left > 0 && master_address == stall_addr) begin
      master_waitrequest = 1'b1;
      stall_left--;
    end else if (rand_wait && master_write) begin
      master_waitrequest = ($urandom_range(0, 3) == 0);
    end else begin
      master_waitrequest = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic present(input logic [8*NB-1:0] blk, input logic [AW-1:0] base);
    in_block  = blk;
    base_addr = base;
    in_valid  = 1'b1;
  endtask

  // Returns #1 after the handshake edge.
  task automatic wait_accept();
    int unsigned n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic release_inputs();
    in_valid  = 1'b0;
    in_block  = {$urandom, $urandom, $urandom, $urandom};
    base_addr = $urandom;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (active && n < 500);
    if (active) check("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  logic [8*NB-1:0] blk0, blk_b;
  int unsigned     n, k;

  initial begin
    blk0 = 128'h00112233445566778899AABBCCDDEEFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", master_write, 0);
    check("rst_addr", master_address, 0);
    check("rst_data", master_writedata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // plain block, no wait states
    present(blk0, 32'h100);
    wait_accept();
    release_inputs();
    wait_idle();

    // three-cycle stall on byte 5
    stall_addr = 32'h105;
    stall_left = 3;
    present(blk0, 32'h100);
    wait_accept();
    release_inputs();
    wait_idle();
    check("stall_consumed", stall_left, 0);

    // second block offered while busy: taken on the next IDLE cycle
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    present(blk0, 32'h300);
    wait_accept();
    present(blk_b, 32'h3A0);
    wait_accept();
    release_inputs();
    wait_idle();
    k = acc_log.size();
    check("b2b_spacing", acc_log[k-1] - acc_log[k-2], NB + 2);

    // reset after byte 7 is accepted
    present({$urandom, $urandom, $urandom, $urandom}, 32'h180);
    wait_accept();
    release_inputs();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (wr_in_blk < 8 && n < 100);
    check("rst_reach_byte7", wr_in_blk, 8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_write", master_write, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    present(blk0, 32'h200);
    wait_accept();
    release_inputs();
    wait_idle();
    check("post_rst_first_addr", first_addr_log[first_addr_log.size()-1], 32'h200);

    // address wrap
    do_reset();
    present(blk0, 32'hFFFF_FFF8);
    wait_accept();
    release_inputs();
    wait_idle();

    // random blocks with random slave stalls
    rand_wait = 1;
    for (int b = 0; b < 6; b++) begin
      present({$urandom, $urandom, $urandom, $urandom}, $urandom);
      wait_accept();
      release_inputs();
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    rand_wait = 0;

    // three back-to-back blocks, base_addr changed after the first
    do_reset();
    present({$urandom, $urandom, $urandom, $urandom}, 32'h400);
    wait_accept();
    present({$urandom, $urandom, $urandom, $urandom}, 32'h900);
    wait_accept();
    present({$urandom, $urandom, $urandom, $urandom}, 32'h900);
    wait_accept();
    release_inputs();
    wait_idle();
    k = first_addr_log.size();
    check("stream_addr0", first_addr_log[k-3], 32'h400);
`ifdef AES_WRITER_AUTOINC_EN
    check("stream_addr1", first_addr_log[k-2], 32'h410);
    check("stream_addr2", first_addr_log[k-1], 32'h420);
`else
    check("stream_addr1", first_addr_log[k-2], 32'h900);
    check("stream_addr2", first_addr_log[k-1], 32'h900);
`endif
    check("queue_drained", exp_addr_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
